// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache refills and dcache
// refills/writebacks. Only one memory transaction is in flight at a time.
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, ties alternate between
// requesters. When undefined, the dcache wins ties.
module mem_arbiter #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  // icache port (reads only)
  input  logic              ic_req_valid,
  input  logic [31:0]       ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  // dcache port (reads and writebacks)
  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [31:0]       dc_req_addr,
  input  logic [DATA_W-1:0] dc_req_data,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  // shared memory port
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [31:0]       mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_dc_q, owner_dc_d;   // 1 = dcache owns the transaction
  logic                rw_q, rw_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ic_resp_valid_q, ic_resp_valid_d;
  logic                dc_resp_valid_q, dc_resp_valid_d;
  logic [DATA_W-1:0]   ic_resp_data_q, ic_resp_data_d;
  logic [DATA_W-1:0]   dc_resp_data_q, dc_resp_data_d;
  logic                grant_dc;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc_q;  // 1 = dcache was granted most recently

  // A tie goes to whichever requester was not granted last.
  assign grant_dc = dc_req_valid && (!ic_req_valid || !last_dc_q);

  // Remember the most recent grant; starts as dcache-last so icache wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dc_q <= 1'b1;
    end else if (state_q == ST_IDLE && (ic_req_valid || dc_req_valid)) begin
      last_dc_q <= grant_dc;
    end
  end
`else
  // Fixed priority: dcache always wins a tie.
  assign grant_dc = dc_req_valid;
`endif

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      owner_dc_q      <= 1'b0;
      rw_q            <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      ic_resp_data_q  <= '0;
      dc_resp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      owner_dc_q      <= owner_dc_d;
      rw_q            <= rw_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      dc_resp_valid_q <= dc_resp_valid_d;
      ic_resp_data_q  <= ic_resp_data_d;
      dc_resp_data_q  <= dc_resp_data_d;
    end
  end

  // Next-state logic, request acceptance and response capture.
  always_comb begin
    state_d         = state_q;
    owner_dc_d      = owner_dc_q;
    rw_d            = rw_q;
    addr_d          = addr_q;
    data_d          = data_q;
    ic_resp_valid_d = 1'b0;
    dc_resp_valid_d = 1'b0;
    ic_resp_data_d  = ic_resp_data_q;
    dc_resp_data_d  = dc_resp_data_q;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ic_req_valid || dc_req_valid) begin
          state_d = ST_ISSUE;
          if (grant_dc) begin
            dc_req_ready = 1'b1;
            owner_dc_d   = 1'b1;
            rw_d         = dc_req_rw;
            addr_d       = dc_req_addr;
            data_d       = dc_req_data;
          end else begin
            ic_req_ready = 1'b1;
            owner_dc_d   = 1'b0;
            rw_d         = 1'b0;   // icache only ever reads
            addr_d       = ic_req_addr;
            data_d       = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_req_ready) begin
          if (rw_q) begin
            // Writebacks complete on acceptance; only the dcache issues them.
            dc_resp_valid_d = 1'b1;
            state_d         = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (owner_dc_q) begin
            dc_resp_valid_d = 1'b1;
            dc_resp_data_d  = mem_resp_data;
          end else begin
            ic_resp_valid_d = 1'b1;
            ic_resp_data_d  = mem_resp_data;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_req_rw    = rw_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign ic_resp_valid = ic_resp_valid_q;
  assign dc_resp_valid = dc_resp_valid_q;
  assign ic_resp_data  = ic_resp_data_q;
  assign dc_resp_data  = dc_resp_data_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change 1 time unit after the
// rising edge; outputs are checked 2 time units after the rising edge.
module tb_mem_arbiter;
  localparam int DW = 128;
  localparam logic [DW-1:0] D1    = {4{32'h1111_0001}};
  localparam logic [DW-1:0] WDAT  = {16{8'hA5}};
  localparam logic [DW-1:0] DA    = {4{32'hAAAA_0003}};
  localparam logic [DW-1:0] DB    = {4{32'hBBBB_0004}};
  localparam logic [DW-1:0] DC    = {4{32'hCCCC_0005}};
  localparam logic [DW-1:0] DD    = {4{32'hDDDD_0006}};
  localparam logic [DW-1:0] JUNK  = {4{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] D5    = {4{32'h5555_0007}};
  localparam logic [DW-1:0] D6    = {4{32'h6666_0008}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [31:0]   ic_req_addr;
  logic [DW-1:0] ic_resp_data;
  logic          dc_req_valid, dc_req_rw, dc_req_ready, dc_resp_valid;
  logic [31:0]   dc_req_addr;
  logic [DW-1:0] dc_req_data, dc_resp_data;
  logic          mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid;
  logic [31:0]   mem_req_addr;
  logic [DW-1:0] mem_req_data, mem_resp_data;
  logic          busy;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [DW-1:0] exp_ic_data, exp_dc_data;

  mem_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy)
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0; dc_req_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    exp_ic_data = '0;
    exp_dc_data = '0;
    tick();
  endtask

  // Both caches request together (dcache read); the first grant goes to dcache
  // when dc_first is set. The loser is accepted in the first grant's response cycle.
  task automatic tie_round(input logic dc_first, input logic [DW-1:0] d1st, input logic [DW-1:0] d2nd);
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_3000;
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 32'h0000_4000;
    settle();
    chk_b("tie_dc_ready", dc_req_ready, dc_first);
    chk_b("tie_ic_ready", ic_req_ready, !dc_first);
    tick();
    if (dc_first) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
    settle();
    chk_a("tie_addr_first", mem_req_addr, dc_first ? 32'h0000_4000 : 32'h0000_3000);
    chk_b("tie_no_ready_busy", ic_req_ready | dc_req_ready, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = d1st;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    settle();
    if (dc_first) exp_dc_data = d1st; else exp_ic_data = d1st;
    chk_b("tie_first_dc_pulse", dc_resp_valid, dc_first);
    chk_b("tie_first_ic_pulse", ic_resp_valid, !dc_first);
    chk_d("tie_first_ic_data", ic_resp_data, exp_ic_data);
    chk_d("tie_first_dc_data", dc_resp_data, exp_dc_data);
    chk_b("tie_second_ready", dc_first ? ic_req_ready : dc_req_ready, 1'b1);
    tick();
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    settle();
    chk_a("tie_addr_second", mem_req_addr, dc_first ? 32'h0000_3000 : 32'h0000_4000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = d2nd;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    settle();
    if (dc_first) exp_ic_data = d2nd; else exp_dc_data = d2nd;
    chk_b("tie_second_ic_pulse", ic_resp_valid, dc_first);
    chk_b("tie_second_dc_pulse", dc_resp_valid, !dc_first);
    chk_d("tie_second_ic_data", ic_resp_data, exp_ic_data);
    chk_d("tie_second_dc_data", dc_resp_data, exp_dc_data);
    tick();
  endtask

  // Service a lone icache read with an immediately ready memory.
  task automatic ic_read(input logic [31:0] addr, input logic [DW-1:0] d);
    ic_req_valid = 1'b1; ic_req_addr = addr;
    settle();
    chk_b("icr_ready", ic_req_ready, 1'b1);
    tick();
    ic_req_valid = 1'b0; ic_req_addr = '0;
    settle();
    chk_a("icr_addr", mem_req_addr, addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = d;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    settle();
    exp_ic_data = d;
    chk_b("icr_pulse", ic_resp_valid, 1'b1);
    chk_d("icr_data", ic_resp_data, exp_ic_data);
    tick();
  endtask

  initial begin
    logic tie_dc_first;
`ifdef ARB_ROUND_ROBIN_EN
    tie_dc_first = 1'b0;
`else
    tie_dc_first = 1'b1;
`endif
    // ---- reset state ----
    reset = 1'b1;
    clear_inputs();
    exp_ic_data = '0;
    exp_dc_data = '0;
    tick();
    tick();
    settle();
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_mem_valid", mem_req_valid, 1'b0);
    chk_b("rst_ic_ready", ic_req_ready, 1'b0);
    chk_b("rst_dc_ready", dc_req_ready, 1'b0);
    chk_b("rst_ic_resp_valid", ic_resp_valid, 1'b0);
    chk_b("rst_dc_resp_valid", dc_resp_valid, 1'b0);
    chk_a("rst_mem_addr", mem_req_addr, 32'h0);
    chk_d("rst_mem_data", mem_req_data, '0);
    chk_d("rst_ic_resp_data", ic_resp_data, '0);
    chk_d("rst_dc_resp_data", dc_resp_data, '0);
    reset = 1'b0;
    tick();

    // ---- lone icache read, memory ready immediately, response 3 cycles later ----
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1000;
    settle();
    chk_b("t1_ic_ready", ic_req_ready, 1'b1);
    chk_b("t1_dc_ready", dc_req_ready, 1'b0);
    tick();
    ic_req_valid = 1'b0; ic_req_addr = '0;
    settle();
    chk_b("t1_mem_valid", mem_req_valid, 1'b1);
    chk_a("t1_mem_addr", mem_req_addr, 32'h0000_1000);
    chk_b("t1_mem_rw", mem_req_rw, 1'b0);
    chk_b("t1_busy", busy, 1'b1);
    chk_b("t1_ic_ready_off", ic_req_ready, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    chk_b("t1_wait_mem_valid", mem_req_valid, 1'b0);
    chk_b("t1_wait_busy", busy, 1'b1);
    tick();
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = D1;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    settle();
    exp_ic_data = D1;
    chk_b("t1_ic_pulse", ic_resp_valid, 1'b1);
    chk_d("t1_ic_data", ic_resp_data, exp_ic_data);
    chk_b("t1_dc_pulse", dc_resp_valid, 1'b0);
    chk_b("t1_idle", busy, 1'b0);
    tick();
    settle();
    chk_b("t1_pulse_end", ic_resp_valid, 1'b0);
    chk_d("t1_data_hold", ic_resp_data, exp_ic_data);

    // ---- dcache writeback, memory ready delayed 4 cycles ----
    dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 32'h0000_2000; dc_req_data = WDAT;
    settle();
    chk_b("t2_dc_ready", dc_req_ready, 1'b1);
    chk_b("t2_ic_ready", ic_req_ready, 1'b0);
    tick();
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = '0; dc_req_data = '0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_b("t2_hold_valid", mem_req_valid, 1'b1);
      chk_b("t2_hold_rw", mem_req_rw, 1'b1);
      chk_a("t2_hold_addr", mem_req_addr, 32'h0000_2000);
      chk_d("t2_hold_data", mem_req_data, WDAT);
      chk_b("t2_no_dc_pulse", dc_resp_valid, 1'b0);
      mem_req_ready = (i == 4);
      tick();
    end
    mem_req_ready = 1'b0;
    settle();
    chk_b("t2_dc_pulse", dc_resp_valid, 1'b1);
    chk_b("t2_ic_pulse", ic_resp_valid, 1'b0);
    chk_b("t2_idle", busy, 1'b0);
    chk_b("t2_mem_valid_off", mem_req_valid, 1'b0);
    chk_d("t2_dc_data_hold", dc_resp_data, exp_dc_data);
    chk_d("t2_ic_data_hold", ic_resp_data, exp_ic_data);
    tick();
    settle();
    chk_b("t2_pulse_end", dc_resp_valid, 1'b0);

    // ---- simultaneous requests, two rounds ----
    do_reset();
    tie_round(tie_dc_first, DA, DB);
    tie_round(tie_dc_first, DC, DD);

    // ---- spurious memory responses in IDLE and ISSUE ----
    mem_resp_valid = 1'b1; mem_resp_data = JUNK;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    settle();
    chk_b("t4_idle_ic_pulse", ic_resp_valid, 1'b0);
    chk_b("t4_idle_dc_pulse", dc_resp_valid, 1'b0);
    chk_b("t4_idle_busy", busy, 1'b0);
    chk_d("t4_idle_ic_data", ic_resp_data, exp_ic_data);
    chk_d("t4_idle_dc_data", dc_resp_data, exp_dc_data);
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_5000;
    tick();
    ic_req_valid = 1'b0; ic_req_addr = '0;
    mem_resp_valid = 1'b1; mem_resp_data = JUNK;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    settle();
    chk_b("t4_issue_held", mem_req_valid, 1'b1);
    chk_b("t4_issue_ic_pulse", ic_resp_valid, 1'b0);
    chk_d("t4_issue_ic_data", ic_resp_data, exp_ic_data);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = D5;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    settle();
    exp_ic_data = D5;
    chk_b("t4_ic_pulse", ic_resp_valid, 1'b1);
    chk_d("t4_ic_data", ic_resp_data, exp_ic_data);
    tick();

    // ---- reset during WAIT ----
    dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 32'h0000_6000;
    tick();
    dc_req_valid = 1'b0; dc_req_addr = '0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    chk_b("t5_wait_busy", busy, 1'b1);
    reset = 1'b1;
    settle();
    chk_b("t5_rst_busy", busy, 1'b0);
    chk_a("t5_rst_addr", mem_req_addr, 32'h0);
    tick();
    reset = 1'b0;
    exp_ic_data = '0;
    exp_dc_data = '0;
    mem_resp_valid = 1'b1; mem_resp_data = JUNK;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    settle();
    chk_b("t5_dc_pulse", dc_resp_valid, 1'b0);
    chk_d("t5_dc_data", dc_resp_data, exp_dc_data);
    chk_d("t5_ic_data", ic_resp_data, exp_ic_data);
    chk_b("t5_busy", busy, 1'b0);
    tick();
    ic_read(32'h0000_7000, D6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  // Guards against a hang if the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
